echo_feedback_mixer: RTL and testbench
======================================

Name: echo_feedback_mixer

Overview:
- Sits around `variable_delay_buffer` and closes the echo loop.
- Write path: forms the buffer's write sample by adding the dry input to the stored feedback term.
- Read path: consumes the delayed tap and produces a wet/dry mixed output, plus the next feedback term.
- Sample-rate strobed, single clock, pipelined multiply and saturate.

Parameters:
- DATA_WIDTH, 32, signed two's-complement sample width; matches the delay buffer.
- GAIN_WIDTH, 16, unsigned Q1.15 gain width; 0x8000 = 1.0.
- SMOOTH_STEP, 16'h0040, maximum gain change per accepted sample (smoothing only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dry_valid  in  1  one-cycle strobe of a new dry sample; also drives the buffer's write strobe.
- dry_in  in  DATA_WIDTH  dry sample.
- tap_valid  in  1  delayed-sample valid from the delay buffer.
- tap_in  in  DATA_WIDTH  delayed sample from the delay buffer.
- dry_gain  in  GAIN_WIDTH  target dry gain.
- wet_gain  in  GAIN_WIDTH  target wet gain.
- fb_gain  in  GAIN_WIDTH  target feedback gain.
- buf_wr_valid  out  1  write strobe to the delay buffer.
- buf_wr_data  out  DATA_WIDTH  write sample to the delay buffer.
- mix_valid  out  1  one-cycle output strobe.
- mix_out  out  DATA_WIDTH  mixed output sample.
- overrun  out  1  sticky flag: dry_valid arrived while busy.

Behaviour:
- Reset (async, active-high): all outputs, fb_reg, products, current gains 0; FSM = IDLE; overrun = 0.
- Write path (combinational from registers):
  - buf_wr_valid = dry_valid when the FSM is in IDLE, else 0.
  - buf_wr_data = sat(dry_in + fb_reg).
- Gain inputs: fb_gain clamps to 0x7FFF (loop stability); dry_gain and wet_gain clamp to 0x8000.
- FSM states: IDLE -> WAIT_TAP -> MUL -> SUM -> IDLE.
  - IDLE: on dry_valid (cycle T), capture dry_in into dry_reg and go to WAIT_TAP.
  - WAIT_TAP (T+1): if tap_valid, tap_reg = tap_in; else tap_reg = 0 (buffer not yet filled). Go to MUL.
  - MUL (T+2): register three products, each 48 bits, signed x zero-extended gain: dry_reg*g_dry, tap_reg*g_wet, tap_reg*g_fb. Go to SUM.
  - SUM (T+3):
    - mix_out = sat((p_dry + p_wet) >>> 15).
    - fb_reg = sat(p_fb >>> 15).
    - mix_valid = 1 for this cycle only.
    - Go to IDLE.
- Latency: mix_valid is high exactly 3 cycles after dry_valid. mix_out holds its value until the next SUM.
- Arithmetic:
  - Shifts are arithmetic.
  - sat() clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - No wrap-around is permitted anywhere.
- Busy collisions: dry_valid while not in IDLE is dropped. No buffer write occurs and overrun sets; overrun clears only on reset.
- Stray tap_valid: ignored outside WAIT_TAP.
- Mid-operation reset: FSM returns to IDLE, and no mix_valid is emitted for the in-flight sample.

Optional Feature:
- Macro: ECHO_MIX_GAIN_SMOOTH_EN.
- Defined: current gains g_* update once per accepted dry_valid (in IDLE).
  - Each gain moves toward its clamped target by min(|target-current|, SMOOTH_STEP).
  - Current gains reset to 0, so the output ramps in from silence.
- Undefined: g_* = clamped targets, latched on accepted dry_valid; the step is immediate.

Decomposition:
- Package echo_pkg holds:
  - typedefs sample_t (signed DATA_WIDTH), gain_t (GAIN_WIDTH), prod_t (48-bit signed);
  - constants GAIN_UNITY = 16'h8000 and FB_GAIN_MAX = 16'h7FFF;
  - enum state_t;
  - a sat_to_sample function.
- One sub-module, gain_smoother: a per-gain ramp register, instantiated three times under the macro.

Test Plan:
- Unity dry, zero wet/fb:
  - Stimulus: dry_gain=0x8000, wet_gain=fb_gain=0; dry_in=1000, tap_valid at T+1.
  - Response: mix_valid at T+3, mix_out=1000; buf_wr_data=1000 at T.
- Half mix:
  - Stimulus: dry_gain=wet_gain=0x4000, dry_in=1000, tap_in=-600.
  - Response: mix_out=200.
- Feedback:
  - Stimulus: fb_gain=0x4000, tap_in=2000; next dry_valid with dry_in=100.
  - Response: buf_wr_data=1100.
- Saturation:
  - Stimulus: dry_in=tap_in=0x7FFFFFFF, both gains 0x8000.
  - Response: mix_out=0x7FFFFFFF. With both inputs 0x80000000: mix_out=0x80000000.
- Missing tap and collision:
  - Missing tap: no tap_valid at T+1 -> mix_out = dry contribution only.
  - Collision: dry_valid at T+1 -> no buf_wr_valid, overrun=1.
- Async reset:
  - Stimulus: reset asserted in MUL.
  - Response: outputs 0 immediately; no mix_valid follows.
  - Smoothing build only: gain step 0 -> 0x8000 takes 512 samples at step 0x40.

Source files
------------

// File: rtl/echo_feedback_mixer_pkg.sv
// Shared types, gain limits, FSM states and the saturation helper for the echo feedback mixer.
package echo_pkg;
  localparam int DATA_W = 32;
  localparam int GAIN_W = 16;
  localparam int PROD_W = 48;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic        [GAIN_W-1:0] gain_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  localparam gain_t GAIN_UNITY  = 16'h8000;
  localparam gain_t FB_GAIN_MAX = 16'h7FFF;

  typedef enum logic [1:0] {IDLE, WAIT_TAP, MUL, SUM} state_t;

  // Clamp a wide signed value into a w-bit two's-complement range; caller narrows the result.
  function automatic logic signed [63:0] sat_to_sample(input logic signed [63:0] v, input int w);
    logic signed [63:0] smax, smin;
    smax = (64'sd1 <<< (w - 1)) - 64'sd1;
    smin = -(64'sd1 <<< (w - 1));
    if (v > smax)      return smax;
    else if (v < smin) return smin;
    else               return v;
  endfunction
endpackage

// File: rtl/echo_feedback_mixer_if.sv
// Sample-stream, gain and status bundle between the echo mixer and its driver.
interface echo_feedback_mixer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int GAIN_WIDTH = 16
);
  logic                         dry_valid;
  logic signed [DATA_WIDTH-1:0] dry_in;
  logic                         tap_valid;
  logic signed [DATA_WIDTH-1:0] tap_in;
  logic        [GAIN_WIDTH-1:0] dry_gain;
  logic        [GAIN_WIDTH-1:0] wet_gain;
  logic        [GAIN_WIDTH-1:0] fb_gain;
  logic                         buf_wr_valid;
  logic signed [DATA_WIDTH-1:0] buf_wr_data;
  logic                         mix_valid;
  logic signed [DATA_WIDTH-1:0] mix_out;
  logic                         overrun;

  modport slave (
    input  dry_valid, dry_in, tap_valid, tap_in, dry_gain, wet_gain, fb_gain,
    output buf_wr_valid, buf_wr_data, mix_valid, mix_out, overrun
  );
  modport master (
    output dry_valid, dry_in, tap_valid, tap_in, dry_gain, wet_gain, fb_gain,
    input  buf_wr_valid, buf_wr_data, mix_valid, mix_out, overrun
  );
endinterface

// File: rtl/echo_feedback_mixer_gain_smoother.sv
// Per-gain ramp register: on each enable, moves cur toward target by at most STEP.
module gain_smoother #(
  parameter int                    GAIN_WIDTH = 16,
  parameter logic [GAIN_WIDTH-1:0] STEP       = 16'h0040
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [GAIN_WIDTH-1:0] target,
  output logic [GAIN_WIDTH-1:0] cur
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= '0;
    else if (en) begin
      if (target > cur) cur <= ((target - cur) > STEP) ? cur + STEP : target;
      else              cur <= ((cur - target) > STEP) ? cur - STEP : target;
    end
  end
endmodule

// File: rtl/echo_feedback_mixer.sv
// Echo loop closer around a delay buffer: feedback write path plus wet/dry mix with saturation.
// Build option ECHO_MIX_GAIN_SMOOTH_EN ramps gains by SMOOTH_STEP per accepted sample.
module echo_feedback_mixer
  import echo_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    GAIN_WIDTH  = 16,
  parameter logic [GAIN_WIDTH-1:0] SMOOTH_STEP = 16'h0040
) (
  input  logic                  clk,
  input  logic                  reset,
  echo_feedback_mixer_if.slave  bus
);
  localparam int PW = DATA_WIDTH + GAIN_WIDTH;

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] dry_reg, tap_reg, fb_reg, mix_hold;
  logic signed [PW-1:0]         p_dry, p_wet, p_fb;
  logic [2:0][GAIN_WIDTH-1:0]   tgt, g;
  logic                         accept, ovr;
  logic signed [63:0]           mix_wide, fb_wide, wr_wide;
  logic signed [DATA_WIDTH-1:0] mix_now, fb_now;

  assign accept = bus.dry_valid && (state == IDLE);

  assign tgt[0] = (bus.dry_gain > GAIN_UNITY)  ? GAIN_UNITY  : bus.dry_gain;
  assign tgt[1] = (bus.wet_gain > GAIN_UNITY)  ? GAIN_UNITY  : bus.wet_gain;
  assign tgt[2] = (bus.fb_gain  > FB_GAIN_MAX) ? FB_GAIN_MAX : bus.fb_gain;

`ifdef ECHO_MIX_GAIN_SMOOTH_EN
  for (genvar i = 0; i < 3; i++) begin : g_smooth
    gain_smoother #(.GAIN_WIDTH(GAIN_WIDTH), .STEP(SMOOTH_STEP)) u_smooth (
      .clk(clk), .reset(reset), .en(accept), .target(tgt[i]), .cur(g[i])
    );
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       g <= '0;
    else if (accept) g <= tgt;
  end
`endif

  // Sums and shifts run at 64 bits so nothing wraps before the clamp.
  assign mix_wide = (64'(p_dry) + 64'(p_wet)) >>> 15;
  assign fb_wide  = 64'(p_fb) >>> 15;
  assign wr_wide  = 64'(bus.dry_in) + 64'(fb_reg);
  assign mix_now  = DATA_WIDTH'(sat_to_sample(mix_wide, DATA_WIDTH));
  assign fb_now   = DATA_WIDTH'(sat_to_sample(fb_wide, DATA_WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dry_reg  <= '0;
      tap_reg  <= '0;
      p_dry    <= '0;
      p_wet    <= '0;
      p_fb     <= '0;
      fb_reg   <= '0;
      mix_hold <= '0;
      ovr      <= 1'b0;
    end else begin
      if (bus.dry_valid && state != IDLE) ovr <= 1'b1;
      case (state)
        IDLE: if (bus.dry_valid) begin
          dry_reg <= bus.dry_in;
          state   <= WAIT_TAP;
        end
        WAIT_TAP: begin
          // A missing tap means the buffer has not filled yet: treat it as silence.
          tap_reg <= bus.tap_valid ? bus.tap_in : '0;
          state   <= MUL;
        end
        MUL: begin
          p_dry <= PW'(dry_reg * $signed({1'b0, g[0]}));
          p_wet <= PW'(tap_reg * $signed({1'b0, g[1]}));
          p_fb  <= PW'(tap_reg * $signed({1'b0, g[2]}));
          state <= SUM;
        end
        SUM: begin
          mix_hold <= mix_now;
          fb_reg   <= fb_now;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.buf_wr_valid = accept;
  assign bus.buf_wr_data  = DATA_WIDTH'(sat_to_sample(wr_wide, DATA_WIDTH));
  assign bus.mix_valid    = (state == SUM);
  assign bus.mix_out      = (state == SUM) ? mix_now : mix_hold;
  assign bus.overrun      = ovr;
endmodule

// File: tb/tb_echo_feedback_mixer.sv
// Directed bench for echo_feedback_mixer (default build, no gain smoothing).
module tb_echo_feedback_mixer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  echo_feedback_mixer_if #(.DATA_WIDTH(32), .GAIN_WIDTH(16)) bus ();

  echo_feedback_mixer #(.DATA_WIDTH(32), .GAIN_WIDTH(16), .SMOOTH_STEP(16'h0040)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic signed [31:0] SMAX = 32'sh7FFFFFFF;
  localparam logic signed [31:0] SMIN = 32'sh80000000;

  typedef struct {
    logic              wr_v;
    logic signed [31:0] wr_d;
    logic              col_v;
    logic              mv2;
    logic              mv3;
    logic signed [31:0] mo3;
    logic              mv4;
    logic signed [31:0] mo4;
  } obs_t;

  task automatic set_gains(input logic [15:0] d, input logic [15:0] w, input logic [15:0] f);
    bus.dry_gain = d;
    bus.wet_gain = w;
    bus.fb_gain  = f;
  endtask

  // One full sample: dry strobe at T, tap at T+1, observe T+2..T+4.
  task automatic run_sample(input logic signed [31:0] d, input logic tv, input logic signed [31:0] tap,
                            input logic collide, output obs_t o);
    @(negedge clk);
    bus.dry_valid = 1'b1; bus.dry_in = d; bus.tap_valid = 1'b0;
    #1 o.wr_v = bus.buf_wr_valid; o.wr_d = bus.buf_wr_data;
    @(negedge clk);
    bus.dry_valid = collide; bus.tap_valid = tv; bus.tap_in = tap;
    #1 o.col_v = bus.buf_wr_valid;
    @(negedge clk);
    bus.dry_valid = 1'b0; bus.tap_valid = 1'b0; bus.tap_in = '0;
    #1 o.mv2 = bus.mix_valid;
    @(negedge clk);
    #1 o.mv3 = bus.mix_valid; o.mo3 = bus.mix_out;
    @(negedge clk);
    #1 o.mv4 = bus.mix_valid; o.mo4 = bus.mix_out;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.dry_valid = 1'b0; bus.dry_in = '0; bus.tap_valid = 1'b0; bus.tap_in = '0;
    set_gains(16'h0, 16'h0, 16'h0);
    @(negedge clk); @(negedge clk);
    total_cnt++; if (bus.mix_valid !== 1'b0) $display("FAIL reset_mix_valid: got %b want 0", bus.mix_valid); else pass_cnt++;
    total_cnt++; if (bus.mix_out !== 32'sd0) $display("FAIL reset_mix_out: got %0d want 0", bus.mix_out); else pass_cnt++;
    total_cnt++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", bus.overrun); else pass_cnt++;
    total_cnt++; if (bus.buf_wr_data !== 32'sd0) $display("FAIL reset_wr_data: got %0d want 0", bus.buf_wr_data); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_unity_dry();
    obs_t o;
    set_gains(16'h8000, 16'h0000, 16'h0000);
    run_sample(32'sd1000, 1'b1, 32'sd555, 1'b0, o);
    total_cnt++; if (o.wr_v !== 1'b1) $display("FAIL unity_wr_valid: got %b want 1", o.wr_v); else pass_cnt++;
    total_cnt++; if (o.wr_d !== 32'sd1000) $display("FAIL unity_wr_data: got %0d want 1000", o.wr_d); else pass_cnt++;
    total_cnt++; if (o.mv2 !== 1'b0) $display("FAIL unity_early_valid: got %b want 0", o.mv2); else pass_cnt++;
    total_cnt++; if (o.mv3 !== 1'b1) $display("FAIL unity_mix_valid: got %b want 1", o.mv3); else pass_cnt++;
    total_cnt++; if (o.mo3 !== 32'sd1000) $display("FAIL unity_mix_out: got %0d want 1000", o.mo3); else pass_cnt++;
    total_cnt++; if (o.mv4 !== 1'b0) $display("FAIL unity_valid_pulse: got %b want 0", o.mv4); else pass_cnt++;
    total_cnt++; if (o.mo4 !== 32'sd1000) $display("FAIL unity_mix_hold: got %0d want 1000", o.mo4); else pass_cnt++;
  endtask

  task automatic test_half_mix();
    obs_t o;
    set_gains(16'h4000, 16'h4000, 16'h0000);
    run_sample(32'sd1000, 1'b1, -32'sd600, 1'b0, o);
    total_cnt++; if (o.mo3 !== 32'sd200) $display("FAIL half_mix_out: got %0d want 200", o.mo3); else pass_cnt++;
  endtask

  task automatic test_feedback();
    obs_t o;
    set_gains(16'h8000, 16'h0000, 16'h4000);
    run_sample(32'sd0, 1'b1, 32'sd2000, 1'b0, o);
    total_cnt++; if (o.mo3 !== 32'sd0) $display("FAIL fb_first_mix: got %0d want 0", o.mo3); else pass_cnt++;
    // fb_reg is 1000 now; missing tap leaves only the dry term in the mix.
    set_gains(16'h8000, 16'h8000, 16'h4000);
    run_sample(32'sd100, 1'b0, 32'sd0, 1'b0, o);
    total_cnt++; if (o.wr_d !== 32'sd1100) $display("FAIL fb_wr_data: got %0d want 1100", o.wr_d); else pass_cnt++;
    total_cnt++; if (o.mo3 !== 32'sd100) $display("FAIL missing_tap_mix: got %0d want 100", o.mo3); else pass_cnt++;
  endtask

  task automatic test_saturation();
    obs_t o;
    // Over-range gains: dry clamps to 1.0, feedback to 0x7FFF.
    set_gains(16'hFFFF, 16'h0000, 16'hFFFF);
    run_sample(32'sd10, 1'b1, 32'sd2000, 1'b0, o);
    total_cnt++; if (o.mo3 !== 32'sd10) $display("FAIL dry_gain_clamp: got %0d want 10", o.mo3); else pass_cnt++;
    set_gains(16'h0000, 16'h0000, 16'h0000);
    run_sample(32'sd0, 1'b0, 32'sd0, 1'b0, o);
    total_cnt++; if (o.wr_d !== 32'sd1999) $display("FAIL fb_gain_clamp: got %0d want 1999", o.wr_d); else pass_cnt++;
    set_gains(16'h0000, 16'h0000, 16'h7FFF);
    run_sample(32'sd0, 1'b1, 32'sd2000, 1'b0, o);
    set_gains(16'h8000, 16'h8000, 16'h0000);
    run_sample(SMAX, 1'b1, SMAX, 1'b0, o);
    total_cnt++; if (o.wr_d !== SMAX) $display("FAIL wr_sat_pos: got %0d want %0d", o.wr_d, SMAX); else pass_cnt++;
    total_cnt++; if (o.mo3 !== SMAX) $display("FAIL mix_sat_pos: got %0d want %0d", o.mo3, SMAX); else pass_cnt++;
    run_sample(SMIN, 1'b1, SMIN, 1'b0, o);
    total_cnt++; if (o.wr_d !== SMIN) $display("FAIL wr_min: got %0d want %0d", o.wr_d, SMIN); else pass_cnt++;
    total_cnt++; if (o.mo3 !== SMIN) $display("FAIL mix_sat_neg: got %0d want %0d", o.mo3, SMIN); else pass_cnt++;
  endtask

  task automatic test_collision();
    obs_t o;
    set_gains(16'h8000, 16'h0000, 16'h0000);
    total_cnt++; if (bus.overrun !== 1'b0) $display("FAIL overrun_pre: got %b want 0", bus.overrun); else pass_cnt++;
    run_sample(32'sd300, 1'b1, 32'sd0, 1'b1, o);
    total_cnt++; if (o.col_v !== 1'b0) $display("FAIL collide_wr_valid: got %b want 0", o.col_v); else pass_cnt++;
    total_cnt++; if (o.mo3 !== 32'sd300) $display("FAIL collide_mix: got %0d want 300", o.mo3); else pass_cnt++;
    total_cnt++; if (bus.overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", bus.overrun); else pass_cnt++;
  endtask

  task automatic test_stray_tap();
    obs_t o;
    @(negedge clk);
    bus.tap_valid = 1'b1; bus.tap_in = 32'sd5000;
    set_gains(16'h8000, 16'h8000, 16'h0000);
    run_sample(32'sd50, 1'b0, 32'sd0, 1'b0, o);
    total_cnt++; if (o.mo3 !== 32'sd50) $display("FAIL stray_tap_mix: got %0d want 50", o.mo3); else pass_cnt++;
    total_cnt++; if (bus.overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", bus.overrun); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    obs_t o;
    int stray;
    set_gains(16'h8000, 16'h0000, 16'h0000);
    @(negedge clk); bus.dry_valid = 1'b1; bus.dry_in = 32'sd77;
    @(negedge clk); bus.dry_valid = 1'b0; bus.dry_in = '0; bus.tap_valid = 1'b1; bus.tap_in = 32'sd10;
    @(negedge clk); bus.tap_valid = 1'b0; bus.tap_in = '0;
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (bus.mix_out !== 32'sd0) $display("FAIL areset_mix_out: got %0d want 0", bus.mix_out); else pass_cnt++;
    total_cnt++; if (bus.overrun !== 1'b0) $display("FAIL areset_overrun: got %b want 0", bus.overrun); else pass_cnt++;
    total_cnt++; if (bus.mix_valid !== 1'b0) $display("FAIL areset_mix_valid: got %b want 0", bus.mix_valid); else pass_cnt++;
    @(negedge clk); reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (bus.mix_valid !== 1'b0) stray++;
    end
    total_cnt++; if (stray !== 0) $display("FAIL areset_no_mix: got %0d strobes want 0", stray); else pass_cnt++;
    run_sample(32'sd40, 1'b1, 32'sd0, 1'b0, o);
    total_cnt++; if (o.mo3 !== 32'sd40) $display("FAIL areset_recover: got %0d want 40", o.mo3); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_unity_dry();
    test_half_mix();
    test_feedback();
    test_saturation();
    test_collision();
    test_stray_tap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
